sr_cmd_gen: RTL
===============

# sr_cmd_gen

SR latch command generator: the driving end of the set/reset interface used by the team's `sr` flip-flop. It accepts target-level requests over a valid/ready handshake and tracks the downstream latch state in a shadow register. When the target level differs from the shadow state, it issues a single clean S or R pulse of programmable width, followed by a programmable guard gap. After the gap it checks the latch's Q feedback and flags mismatches. It sits upstream of one `sr` instance and guarantees that the downstream latch never sees S=R=1.

## Interface
Parameters:
- PULSE_W, default 1: cycles S or R is held high per command; legal range 1..255.
- GAP_W, default 1: idle cycles after each pulse before the next acceptance; legal range 1..255.
- ERR_W, default 8: width of the mismatch counter.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising-edge.
- rst  in  1  synchronous active-high reset, sampled on the rising edge of clk.
- req_valid  in  1  request present.
- req_level  in  1  target latch level.
- req_force  in  1  issue the pulse even if req_level equals shadow_q.
- req_ready  out  1  block can accept a request this cycle.
- S  out  1  set command to the latch, registered.
- R  out  1  reset command to the latch, registered.
- shadow_q  out  1  expected latch state.
- busy  out  1  a command is in the PULSE or GAP phase.
- q_fb  in  1  latch Q feedback.
- err_clr  in  1  clears err_flag and err_cnt.
- err_flag  out  1  sticky mismatch flag.
- err_cnt  out  ERR_W  saturating mismatch count.

## Operation
- FSM states: IDLE, PULSE, GAP. A single down-counter is shared between PULSE and GAP.
- IDLE:
  - req_ready=1 and S=R=0.
  - On req_valid, the request is accepted.
  - If req_level≠shadow_q or req_force=1: the request is effective. Load shadow_q←req_level, load counter←PULSE_W-1, go to PULSE.
  - Otherwise the request is a no-op. Stay in IDLE; no pulse and no check.
- PULSE:
  - S=shadow_q and R=~shadow_q.
  - When the counter reaches 0: load counter←GAP_W-1 and go to GAP.
  - Otherwise decrement the counter.
- GAP:
  - S=R=0.
  - On the last GAP cycle (counter=0), compare q_fb with shadow_q. On mismatch: err_flag←1, and err_cnt←err_cnt+1, saturating at all-ones.
  - Then go to IDLE.
- busy=1 in PULSE and GAP. req_ready=~busy and is 0 during reset.
- Invariant: S&R is never 1 in any cycle, including reset and its release.
- err_clr:
  - Clears err_flag and err_cnt at the next edge.
  - If a mismatch occurs in the same cycle as err_clr, the mismatch wins: err_flag=1, err_cnt=1.
- Requests arriving while req_ready=0 are neither accepted nor queued; the upstream source must hold req_valid.

## Timing
- Reset values: S=0, R=0, shadow_q=0 (matches the latch reset value), busy=0, req_ready=0 while rst=1, err_flag=0, err_cnt=0, state IDLE.
- Reset asserted mid-PULSE: S and R go to 0 at that same edge, shadow_q goes to 0, and no check is performed.
- Accept edge e0 (IDLE, valid&&ready):
  - S or R is high for cycles e0+1 .. e0+PULSE_W.
  - GAP covers the next GAP_W cycles.
  - req_ready returns to 1 at e0+PULSE_W+GAP_W+1.
- Minimum spacing between effective requests is 1+PULSE_W+GAP_W cycles. No-op requests can be accepted every cycle.
- q_fb is sampled PULSE_W+GAP_W cycles after accept. The latch updates one edge after S or R is seen, so with GAP_W≥1 the feedback is already settled when sampled.
- err_flag and err_cnt update at the edge that ends the last GAP cycle.

## Test plan
- Reset, then hold idle for 5 cycles. Expect S=R=0, shadow_q=0, req_ready=1 from the first post-reset cycle, err_cnt=0.
- PULSE_W=3, GAP_W=2, request level=1, with the latch model attached:
  - S is high for exactly 3 cycles and R stays 0.
  - req_ready is low for 5 cycles.
  - shadow_q=1 and err_flag=0.
- Request level=1 again with req_force=0. Expect no pulse and req_ready to stay 1. Then request level=1 with req_force=1. Expect a 3-cycle S pulse.
- Tie q_fb=0 and request level 1 three times, alternating with level 0. Expect err_cnt=2 and err_flag=1. Then assert err_clr, pulsed with no mismatch. Expect err_cnt=0 and err_flag=0.
- Assert rst at cycle 2 of a PULSE. Expect S=0 at that edge, shadow_q=0, and no err increment. Throughout all tests, assert S&R==0 on every cycle.
- ERR_W=2 with a forced mismatch 5 times. Expect err_cnt to saturate at 3.

Source files
------------

// File: rtl/sr_cmd_gen.sv
// Set/reset command generator for a downstream SR latch: turns target-level requests
// into one clean S or R pulse, a guard gap, and a Q-feedback check with error counting.
module sr_cmd_gen #(
   parameter int unsigned PULSE_W = 1,
   parameter int unsigned GAP_W   = 1,
   parameter int unsigned ERR_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic             req_level,
   input  logic             req_force,
   output logic             req_ready,
   output logic             S,
   output logic             R,
   output logic             shadow_q,
   output logic             busy,
   input  logic             q_fb,
   input  logic             err_clr,
   output logic             err_flag,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [7:0]       PULSE_LD = 8'(PULSE_W - 1);
   localparam logic [7:0]       GAP_LD   = 8'(GAP_W - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;
   localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

   state_t           state, state_d;
   logic [7:0]       ctr, ctr_d;
   logic             shadow_d;
   logic             s_d, r_d;
   logic             err_flag_d;
   logic [ERR_W-1:0] err_cnt_d;
   logic             mismatch;

   assign busy      = (state != IDLE);
   assign req_ready = (state == IDLE) && !rst;
   assign mismatch  = (q_fb != shadow_q);

   // S and R are decoded here and registered below, so the latch only ever sees
   // flop outputs and the two can never be high together.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves
      // a variable unassigned, which would otherwise infer a latch.
      state_d    = state;
      ctr_d      = ctr;
      shadow_d   = shadow_q;
      s_d        = 1'b0;
      r_d        = 1'b0;
      err_flag_d = err_flag;
      err_cnt_d  = err_cnt;

      if (err_clr) begin
         err_flag_d = 1'b0;
         err_cnt_d  = '0;
      end

      case (state)
         IDLE: begin
            if (req_valid && ((req_level != shadow_q) || req_force)) begin
               shadow_d = req_level;
               ctr_d    = PULSE_LD;
               state_d  = PULSE;
               s_d      = req_level;
               r_d      = !req_level;
            end
         end

         PULSE: begin
            if (ctr == 8'd0) begin
               ctr_d   = GAP_LD;
               state_d = GAP;
            end else begin
               ctr_d = ctr - 8'd1;
               s_d   = shadow_q;
               r_d   = !shadow_q;
            end
         end

         GAP: begin
            if (ctr == 8'd0) begin
               state_d = IDLE;
               // A mismatch on the check edge wins over a simultaneous clear.
               if (mismatch) begin
                  err_flag_d = 1'b1;
                  if (err_clr) begin
                     err_cnt_d = ERR_ONE;
                  end else if (err_cnt != ERR_MAX) begin
                     err_cnt_d = err_cnt + ERR_ONE;
                  end
               end
            end else begin
               ctr_d = ctr - 8'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      if (rst) begin
         state    <= IDLE;
         ctr      <= 8'd0;
         shadow_q <= 1'b0;
         S        <= 1'b0;
         R        <= 1'b0;
         err_flag <= 1'b0;
         err_cnt  <= '0;
      end else begin
         state    <= state_d;
         ctr      <= ctr_d;
         shadow_q <= shadow_d;
         S        <= s_d;
         R        <= r_d;
         err_flag <= err_flag_d;
         err_cnt  <= err_cnt_d;
      end
   end

endmodule
